// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer in front of the ALU: 4-cycle IDLE/READ/EXEC/WB.
// Optional perf counters (retire_cnt, jump_cnt) under ISSUE_PERF_CNT_EN.
module alu_issue_ctrl #(
    parameter int word_size     = 32,
    parameter int opcode_size   = 4,
    parameter int mode_size     = 2,
    parameter int reg_addr_size = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [word_size-1:0]     instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    output logic [opcode_size-1:0]   opcode,
    output logic [mode_size-1:0]     mode,
    output logic [word_size-1:0]     data_1,
    output logic [word_size-1:0]     data_2,
    output logic                     alu_enable,
    output logic                     alu_zero,
    input  logic [word_size-1:0]     alu_out,
    input  logic                     alu_one,
    output logic                     done,
    output logic                     illegal,
    output logic                     jump_valid,
    output logic [15:0]              jump_target,
`ifdef ISSUE_PERF_CNT_EN
    output logic [15:0]              retire_cnt,
    output logic [15:0]              jump_cnt,
`endif
    input  logic [reg_addr_size-1:0] dbg_addr,
    output logic [word_size-1:0]     dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    state_t                   r_state;
    logic [word_size-1:0]     r_instr;
    logic [word_size-1:0]     r_result;
    logic [word_size-1:0]     r_rf [2**reg_addr_size];
    logic [opcode_size-1:0]   r_opcode;
    logic [mode_size-1:0]     r_mode;
    logic [word_size-1:0]     r_data_1;
    logic [word_size-1:0]     r_data_2;
    logic                     r_alu_enable;
    logic                     r_alu_zero;
    logic                     r_done;
    logic                     r_illegal;
    logic                     r_jump_valid;
    logic [15:0]              r_jump_target;

    logic [3:0]               w_op;
    logic [1:0]               w_mode;
    logic [2:0]               w_rd;
    logic [2:0]               w_rs1;
    logic [2:0]               w_rs2;
    logic                     w_nojump;
    logic [15:0]              w_target;
    logic [word_size-1:0]     w_rs1_val;
    logic [word_size-1:0]     w_rs2_val;

    assign w_op      = r_instr[31:28];
    assign w_mode    = r_instr[27:26];
    assign w_rd      = r_instr[25:23];
    assign w_rs1     = r_instr[22:20];
    assign w_rs2     = r_instr[19:17];
    assign w_nojump  = r_instr[16];
    assign w_target  = r_instr[15:0];

    // r0 is hard-wired to zero on every read port
    assign w_rs1_val = (w_rs1 == 3'd0) ? '0 : r_rf[w_rs1];
    assign w_rs2_val = (w_rs2 == 3'd0) ? '0 : r_rf[w_rs2];
    assign dbg_data  = (dbg_addr == '0) ? '0 : r_rf[dbg_addr];

    assign instr_ready = (r_state == S_IDLE) && !reset;
    assign opcode      = r_opcode;
    assign mode        = r_mode;
    assign data_1      = r_data_1;
    assign data_2      = r_data_2;
    assign alu_enable  = r_alu_enable;
    assign alu_zero    = r_alu_zero;
    assign done        = r_done;
    assign illegal     = r_illegal;
    assign jump_valid  = r_jump_valid;
    assign jump_target = r_jump_target;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_instr       <= '0;
            r_result      <= '0;
            r_opcode      <= '0;
            r_mode        <= '0;
            r_data_1      <= '0;
            r_data_2      <= '0;
            r_alu_enable  <= 1'b0;
            r_alu_zero    <= 1'b0;
            r_done        <= 1'b0;
            r_illegal     <= 1'b0;
            r_jump_valid  <= 1'b0;
            r_jump_target <= '0;
            for (int i = 0; i < 2**reg_addr_size; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_alu_enable <= 1'b0;
            r_done       <= 1'b0;
            r_illegal    <= 1'b0;
            r_jump_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_instr <= instr;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_data_1     <= w_rs1_val;
                    r_data_2     <= w_rs2_val;
                    r_opcode     <= w_op;
                    r_mode       <= w_mode;
                    r_alu_zero   <= w_nojump;
                    r_alu_enable <= !w_mode[1];
                    r_state      <= S_EXEC;
                end
                S_EXEC: begin
                    r_result  <= alu_out;
                    r_done    <= 1'b1;
                    r_illegal <= w_mode[1];
                    if ((w_mode == 2'd1) && alu_one) begin
                        r_jump_valid  <= 1'b1;
                        r_jump_target <= w_target;
                    end
                    r_state <= S_WB;
                end
                S_WB: begin
                    if ((w_mode == 2'd0) && (w_rd != 3'd0)) begin
                        r_rf[w_rd] <= r_result;
                    end
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic [15:0] r_retire_cnt;
    logic [15:0] r_jump_cnt;

    assign retire_cnt = r_retire_cnt;
    assign jump_cnt   = r_jump_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retire_cnt <= '0;
            r_jump_cnt   <= '0;
        end else begin
            if (r_done) r_retire_cnt <= r_retire_cnt + 16'd1;
            if (r_jump_valid) r_jump_cnt <= r_jump_cnt + 16'd1;
        end
    end
`endif

endmodule
